// File: rtl/multi_cycle_ctr.sv
// rtl/multi_cycle_ctr.sv - multi-cycle MIPS main control FSM with bounded memory-ready wait
module multi_cycle_ctr #(
   parameter int MEM_WAIT_EN = 1,
   parameter int WAIT_LIMIT  = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] OpCode,
   input  logic       memReady,
   output logic       pcWrite,
   output logic       pcWriteCond,
   output logic       branchNe,
   output logic [1:0] pcSource,
   output logic       iorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       irWrite,
   output logic       regDst,
   output logic       memToReg,
   output logic       regWrite,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [2:0] aluOp,
   output logic       instrDone,
   output logic       illegalOp,
   output logic       memTimeout,
   output logic [3:0] state
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_R_EXEC    = 4'd7,
      S_R_WB      = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_IMM_EXEC  = 4'd11,
      S_IMM_WB    = 4'd12,
      S_HALT      = 4'd13
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [CW-1:0]   r_wait_cnt;
   logic            r_timeout;
   logic            w_ready;
   logic            w_mem_state;
   logic            w_waiting;
   logic            w_expire;

   // With waiting disabled the memory is treated as always ready.
   assign w_ready     = (MEM_WAIT_EN != 0) ? memReady : 1'b1;
   assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
   assign w_waiting   = w_mem_state && !w_ready;
   assign w_expire    = w_waiting && (r_wait_cnt == CW'(WAIT_LIMIT - 1));

   assign memTimeout = r_timeout;
   assign state      = r_state;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_wait_cnt <= w_waiting ? r_wait_cnt + 1'b1 : '0;
         if (w_expire) begin
            r_timeout <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next      = S_IDLE;
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      branchNe    = 1'b0;
      pcSource    = 2'b00;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      regDst      = 1'b0;
      memToReg    = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = 2'b00;
      aluOp       = 3'b000;
      instrDone   = 1'b0;
      illegalOp   = 1'b0;
      case (r_state)
         S_IDLE: w_next = S_FETCH;
         S_FETCH: begin
            memRead = 1'b1;
            aluSrcB = 2'b01;
            irWrite = w_ready;
            pcWrite = w_ready;
            w_next  = w_expire ? S_HALT : (w_ready ? S_DECODE : S_FETCH);
         end
         S_DECODE: begin
            aluSrcB = 2'b11;
            case (OpCode)
               OP_RTYPE:               w_next = S_R_EXEC;
               OP_LW, OP_SW:           w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE:         w_next = S_BRANCH;
               OP_J:                   w_next = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI: w_next = S_IMM_EXEC;
               default: begin
                  illegalOp = 1'b1;
                  instrDone = 1'b1;
                  w_next    = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            w_next  = (OpCode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            memRead = 1'b1;
            iorD    = 1'b1;
            w_next  = w_expire ? S_HALT : (w_ready ? S_MEM_WB : S_MEM_READ);
         end
         S_MEM_WB: begin
            memToReg  = 1'b1;
            regWrite  = 1'b1;
            instrDone = 1'b1;
            w_next    = S_FETCH;
         end
         S_MEM_WRITE: begin
            memWrite  = 1'b1;
            iorD      = 1'b1;
            instrDone = w_ready;
            w_next    = w_expire ? S_HALT : (w_ready ? S_FETCH : S_MEM_WRITE);
         end
         S_R_EXEC: begin
            aluSrcA = 1'b1;
            aluOp   = 3'b010;
            w_next  = S_R_WB;
         end
         S_R_WB: begin
            regDst    = 1'b1;
            regWrite  = 1'b1;
            instrDone = 1'b1;
            w_next    = S_FETCH;
         end
         S_BRANCH: begin
            aluSrcA     = 1'b1;
            aluOp       = 3'b001;
            pcWriteCond = 1'b1;
            pcSource    = 2'b01;
            branchNe    = (OpCode == OP_BNE);
            instrDone   = 1'b1;
            w_next      = S_FETCH;
         end
         S_JUMP: begin
            pcWrite   = 1'b1;
            pcSource  = 2'b10;
            instrDone = 1'b1;
            w_next    = S_FETCH;
         end
         S_IMM_EXEC: begin
            aluSrcA = 1'b1;
            aluSrcB = 2'b10;
            case (OpCode)
               OP_ANDI: aluOp = 3'b011;
               OP_ORI:  aluOp = 3'b100;
               default: aluOp = 3'b000;
            endcase
            w_next = S_IMM_WB;
         end
         S_IMM_WB: begin
            regWrite  = 1'b1;
            instrDone = 1'b1;
            w_next    = S_FETCH;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multi_cycle_ctr.sv
// tb/tb_multi_cycle_ctr.sv - table-driven bench for multi_cycle_ctr
module tb_multi_cycle_ctr;

   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       branchNe;
      logic [1:0] pcSource;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       regDst;
      logic       memToReg;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [2:0] aluOp;
      logic       instrDone;
      logic       illegalOp;
      logic       memTimeout;
   } outs_t;

   typedef struct {
      logic [5:0] op;
      logic       rdy;
      logic [3:0] st;
      outs_t      exp;
   } vec_t;

   localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DEC = 4'd2, ST_MA = 4'd3;
   localparam logic [3:0] ST_MRD = 4'd4, ST_MWB = 4'd5, ST_MWR = 4'd6, ST_REX = 4'd7;
   localparam logic [3:0] ST_RWB = 4'd8, ST_BR = 4'd9, ST_J = 4'd10, ST_IEX = 4'd11;
   localparam logic [3:0] ST_IWB = 4'd12, ST_HALT = 4'd13;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
   localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
   localparam logic [5:0] RT = 6'b000000, BAD = 6'b111111;

   localparam outs_t O_IDLE  = '0;
   localparam outs_t O_FW    = '{memRead: 1, aluSrcB: 2'b01, default: 0};
   localparam outs_t O_FR    = '{memRead: 1, aluSrcB: 2'b01, irWrite: 1, pcWrite: 1, default: 0};
   localparam outs_t O_DEC   = '{aluSrcB: 2'b11, default: 0};
   localparam outs_t O_ILL   = '{aluSrcB: 2'b11, illegalOp: 1, instrDone: 1, default: 0};
   localparam outs_t O_MA    = '{aluSrcA: 1, aluSrcB: 2'b10, default: 0};
   localparam outs_t O_MRD   = '{memRead: 1, iorD: 1, default: 0};
   localparam outs_t O_MWB   = '{memToReg: 1, regWrite: 1, instrDone: 1, default: 0};
   localparam outs_t O_MWW   = '{memWrite: 1, iorD: 1, default: 0};
   localparam outs_t O_MWR   = '{memWrite: 1, iorD: 1, instrDone: 1, default: 0};
   localparam outs_t O_REX   = '{aluSrcA: 1, aluOp: 3'b010, default: 0};
   localparam outs_t O_RWB   = '{regDst: 1, regWrite: 1, instrDone: 1, default: 0};
   localparam outs_t O_BEQ   = '{aluSrcA: 1, aluOp: 3'b001, pcWriteCond: 1, pcSource: 2'b01, instrDone: 1, default: 0};
   localparam outs_t O_BNE   = '{aluSrcA: 1, aluOp: 3'b001, pcWriteCond: 1, pcSource: 2'b01, instrDone: 1, branchNe: 1, default: 0};
   localparam outs_t O_J     = '{pcWrite: 1, pcSource: 2'b10, instrDone: 1, default: 0};
   localparam outs_t O_IADD  = '{aluSrcA: 1, aluSrcB: 2'b10, aluOp: 3'b000, default: 0};
   localparam outs_t O_IAND  = '{aluSrcA: 1, aluSrcB: 2'b10, aluOp: 3'b011, default: 0};
   localparam outs_t O_IOR   = '{aluSrcA: 1, aluSrcB: 2'b10, aluOp: 3'b100, default: 0};
   localparam outs_t O_IWB   = '{regWrite: 1, instrDone: 1, default: 0};
   localparam outs_t O_HALT  = '{memTimeout: 1, default: 0};

   logic clk = 1'b0;
   logic reset, rst_nw, rdy, rdy_nw;
   logic [5:0] op;

   logic m_pcWrite, m_pcWriteCond, m_branchNe, m_iorD, m_memRead, m_memWrite, m_irWrite;
   logic m_regDst, m_memToReg, m_regWrite, m_aluSrcA, m_instrDone, m_illegalOp, m_memTimeout;
   logic [1:0] m_pcSource, m_aluSrcB;
   logic [2:0] m_aluOp;
   logic [3:0] m_state;
   logic n_pcWrite, n_pcWriteCond, n_branchNe, n_iorD, n_memRead, n_memWrite, n_irWrite;
   logic n_regDst, n_memToReg, n_regWrite, n_aluSrcA, n_instrDone, n_illegalOp, n_memTimeout;
   logic [1:0] n_pcSource, n_aluSrcB;
   logic [2:0] n_aluOp;
   logic [3:0] n_state;
   outs_t got_m, got_n;

   int checks = 0;
   int errors = 0;
   vec_t vm[$];
   vec_t vn[$];

   always #5 clk = ~clk;

   multi_cycle_ctr #(.MEM_WAIT_EN(1), .WAIT_LIMIT(4)) dut (
      .clk(clk), .reset(reset), .OpCode(op), .memReady(rdy),
      .pcWrite(m_pcWrite), .pcWriteCond(m_pcWriteCond), .branchNe(m_branchNe), .pcSource(m_pcSource),
      .iorD(m_iorD), .memRead(m_memRead), .memWrite(m_memWrite), .irWrite(m_irWrite),
      .regDst(m_regDst), .memToReg(m_memToReg), .regWrite(m_regWrite), .aluSrcA(m_aluSrcA),
      .aluSrcB(m_aluSrcB), .aluOp(m_aluOp), .instrDone(m_instrDone), .illegalOp(m_illegalOp),
      .memTimeout(m_memTimeout), .state(m_state)
   );

   multi_cycle_ctr #(.MEM_WAIT_EN(0), .WAIT_LIMIT(4)) dut_nw (
      .clk(clk), .reset(rst_nw), .OpCode(op), .memReady(rdy_nw),
      .pcWrite(n_pcWrite), .pcWriteCond(n_pcWriteCond), .branchNe(n_branchNe), .pcSource(n_pcSource),
      .iorD(n_iorD), .memRead(n_memRead), .memWrite(n_memWrite), .irWrite(n_irWrite),
      .regDst(n_regDst), .memToReg(n_memToReg), .regWrite(n_regWrite), .aluSrcA(n_aluSrcA),
      .aluSrcB(n_aluSrcB), .aluOp(n_aluOp), .instrDone(n_instrDone), .illegalOp(n_illegalOp),
      .memTimeout(n_memTimeout), .state(n_state)
   );

   assign got_m = {m_pcWrite, m_pcWriteCond, m_branchNe, m_pcSource, m_iorD, m_memRead, m_memWrite,
                   m_irWrite, m_regDst, m_memToReg, m_regWrite, m_aluSrcA, m_aluSrcB, m_aluOp,
                   m_instrDone, m_illegalOp, m_memTimeout};
   assign got_n = {n_pcWrite, n_pcWriteCond, n_branchNe, n_pcSource, n_iorD, n_memRead, n_memWrite,
                   n_irWrite, n_regDst, n_memToReg, n_regWrite, n_aluSrcA, n_aluSrcB, n_aluOp,
                   n_instrDone, n_illegalOp, n_memTimeout};

   task automatic add_m(input logic [5:0] o, input logic r, input logic [3:0] s, input outs_t e);
      vec_t v;
      v.op = o; v.rdy = r; v.st = s; v.exp = e;
      vm.push_back(v);
   endtask

   task automatic add_n(input logic [5:0] o, input logic [3:0] s, input outs_t e);
      vec_t v;
      v.op = o; v.rdy = 1'b0; v.st = s; v.exp = e;
      vn.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [3:0] st_got, input logic [3:0] st_exp,
                      input outs_t o_got, input outs_t o_exp);
      checks++;
      if (st_got !== st_exp) begin
         errors++;
         $display("FAIL %s[%0d] state: got %0d expected %0d", name, idx, st_got, st_exp);
      end
      checks++;
      if (o_got !== o_exp) begin
         errors++;
         $display("FAIL %s[%0d] outputs: got %h expected %h", name, idx, o_got, o_exp);
      end
   endtask

   initial begin
      reset = 1'b1; rst_nw = 1'b1; rdy = 1'b0; rdy_nw = 1'b0; op = RT;

      // R-type, lw with 3 read waits, bne, beq, ori, andi, addi (1 fetch wait), j
      add_m(RT, 1, ST_IDLE, O_IDLE);
      add_m(RT, 1, ST_FETCH, O_FR); add_m(RT, 1, ST_DEC, O_DEC);
      add_m(RT, 1, ST_REX, O_REX);  add_m(RT, 1, ST_RWB, O_RWB);
      add_m(LW, 1, ST_FETCH, O_FR); add_m(LW, 1, ST_DEC, O_DEC); add_m(LW, 1, ST_MA, O_MA);
      for (int i = 0; i < 3; i++) add_m(LW, 0, ST_MRD, O_MRD);
      add_m(LW, 1, ST_MRD, O_MRD);  add_m(LW, 1, ST_MWB, O_MWB);
      add_m(BNE, 1, ST_FETCH, O_FR); add_m(BNE, 1, ST_DEC, O_DEC); add_m(BNE, 1, ST_BR, O_BNE);
      add_m(BEQ, 1, ST_FETCH, O_FR); add_m(BEQ, 1, ST_DEC, O_DEC); add_m(BEQ, 1, ST_BR, O_BEQ);
      add_m(ORI, 1, ST_FETCH, O_FR); add_m(ORI, 1, ST_DEC, O_DEC);
      add_m(ORI, 1, ST_IEX, O_IOR);  add_m(ORI, 1, ST_IWB, O_IWB);
      add_m(ANDI, 1, ST_FETCH, O_FR); add_m(ANDI, 1, ST_DEC, O_DEC);
      add_m(ANDI, 1, ST_IEX, O_IAND); add_m(ANDI, 1, ST_IWB, O_IWB);
      add_m(ADDI, 0, ST_FETCH, O_FW); add_m(ADDI, 1, ST_FETCH, O_FR); add_m(ADDI, 1, ST_DEC, O_DEC);
      add_m(ADDI, 1, ST_IEX, O_IADD); add_m(ADDI, 1, ST_IWB, O_IWB);
      add_m(JMP, 1, ST_FETCH, O_FR); add_m(JMP, 1, ST_DEC, O_DEC); add_m(JMP, 1, ST_J, O_J);
      // sw: ready arrives on the limit cycle of fetch, then 2 write waits
      for (int i = 0; i < 3; i++) add_m(SW, 0, ST_FETCH, O_FW);
      add_m(SW, 1, ST_FETCH, O_FR); add_m(SW, 1, ST_DEC, O_DEC); add_m(SW, 1, ST_MA, O_MA);
      add_m(SW, 0, ST_MWR, O_MWW);  add_m(SW, 0, ST_MWR, O_MWW); add_m(SW, 1, ST_MWR, O_MWR);
      add_m(BAD, 1, ST_FETCH, O_FR); add_m(BAD, 1, ST_DEC, O_ILL);
      // timeout: four low cycles in fetch, then sticky HALT
      for (int i = 0; i < 4; i++) add_m(RT, 0, ST_FETCH, O_FW);
      add_m(RT, 0, ST_HALT, O_HALT); add_m(RT, 1, ST_HALT, O_HALT); add_m(RT, 1, ST_HALT, O_HALT);

      add_n(SW, ST_IDLE, O_IDLE); add_n(SW, ST_FETCH, O_FR); add_n(SW, ST_DEC, O_DEC);
      add_n(SW, ST_MA, O_MA);     add_n(SW, ST_MWR, O_MWR);
      add_n(LW, ST_FETCH, O_FR);  add_n(LW, ST_DEC, O_DEC); add_n(LW, ST_MA, O_MA);
      add_n(LW, ST_MRD, O_MRD);   add_n(LW, ST_MWB, O_MWB); add_n(RT, ST_FETCH, O_FR);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset", 0, m_state, ST_IDLE, got_m, O_IDLE);
      reset = 1'b0;

      for (int i = 0; i < vm.size(); i++) begin
         if (i != 0) @(negedge clk);
         op = vm[i].op; rdy = vm[i].rdy;
         #1 chk("main", i, m_state, vm[i].st, got_m, vm[i].exp);
      end

      // reset out of HALT, then reset in the middle of a fetch wait
      @(negedge clk); reset = 1'b1; rdy = 1'b0;
      @(negedge clk); #1 chk("halt_reset", 0, m_state, ST_IDLE, got_m, O_IDLE);
      reset = 1'b0;
      @(negedge clk); #1 chk("wait_reset", 0, m_state, ST_FETCH, got_m, O_FW);
      @(negedge clk); #1 chk("wait_reset", 1, m_state, ST_FETCH, got_m, O_FW);
      reset = 1'b1;
      @(negedge clk); #1 chk("wait_reset", 2, m_state, ST_IDLE, got_m, O_IDLE);

      // no-wait variant: memReady stuck low never stalls or times out
      rst_nw = 1'b0;
      for (int i = 0; i < vn.size(); i++) begin
         if (i != 0) @(negedge clk);
         op = vn[i].op;
         #1 chk("nowait", i, n_state, vn[i].st, got_n, vn[i].exp);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_cycle_ctr.md
# multi_cycle_ctr

Multi-cycle main control unit for the MIPS datapath, successor to the single-cycle opcode decoder. A state machine sequences each instruction through fetch, decode, execute, memory and writeback. It drives per-state datapath enables and waits on a memory ready handshake with a bounded timeout. The instruction set is extended with bne, addi, andi and ori; the block sits between the instruction register's opcode field and the shared-memory multi-cycle datapath.

## Interface
- MEM_WAIT_EN, 1, 1: memory states wait for memReady; 0: memReady treated as constant 1
- WAIT_LIMIT, 255, consecutive memReady-low cycles tolerated before timeout (≥1); counter width clog2(WAIT_LIMIT+1)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- OpCode  in  6  instruction[31:26] from IR; stable outside FETCH
- memReady  in  1  memory completes current access this cycle
- pcWrite, pcWriteCond, branchNe  out  1  PC unconditional write / conditional write / condition is "not zero"
- pcSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- iorD, memRead, memWrite, irWrite  out  1  memory address select (1=ALUOut) / read / write / IR load
- regDst, memToReg, regWrite  out  1  rd select / memory-data writeback / register file write
- aluSrcA  out  1  0 PC, 1 regA
- aluSrcB  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- aluOp  out  3  000 add, 001 sub, 010 funct field, 011 and, 100 or
- instrDone  out  1  pulse in the last state of each instruction
- illegalOp  out  1  pulse in DECODE when opcode is unsupported
- memTimeout  out  1  sticky; set on wait timeout, cleared only by reset
- state  out  4  current state encoding (debug)

## Operation
- Encoding: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, IMM_EXEC 11, IMM_WB 12, HALT 13; 14/15 → IDLE.
- Outputs not listed below are 0 in that state.
- IDLE: all outputs 0 → FETCH.
- FETCH: memRead=1, aluSrcB=01, aluOp=000.
  - irWrite and pcWrite are asserted only when memReady=1 (Mealy gating).
  - memReady → DECODE; otherwise stay.
- DECODE: aluSrcB=11, aluOp=000.
  - 000000 → R_EXEC; 100011/101011 → MEM_ADDR; 000100/000101 → BRANCH; 000010 → JUMP; 001000/001100/001101 → IMM_EXEC.
  - Any other opcode: illegalOp=1, instrDone=1, → FETCH.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=000; lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: memRead=1, iorD=1; memReady → MEM_WB.
- MEM_WB: memToReg=1, regWrite=1, instrDone=1 → FETCH.
- MEM_WRITE: memWrite=1, iorD=1; instrDone=memReady; memReady → FETCH.
- R_EXEC: aluSrcA=1, aluSrcB=00, aluOp=010 → R_WB.
- R_WB: regDst=1, regWrite=1, instrDone=1 → FETCH.
- BRANCH: aluSrcA=1, aluOp=001, pcWriteCond=1, pcSource=01, instrDone=1 → FETCH.
  - branchNe=1 only for opcode 000101.
- JUMP: pcWrite=1, pcSource=10, instrDone=1 → FETCH.
- IMM_EXEC: aluSrcA=1, aluSrcB=10; aluOp 000 addi, 011 andi, 100 ori → IMM_WB.
- IMM_WB: regWrite=1, instrDone=1 → FETCH.
- Wait counter:
  - Increments each cycle the FSM is in FETCH/MEM_READ/MEM_WRITE with memReady=0.
  - Clears on memReady=1 or on any other state.
  - When count reaches WAIT_LIMIT with memReady still 0: next state HALT, memTimeout set.
- HALT: all outputs 0 except memTimeout; exits only via reset.
- MEM_WAIT_EN=0: counter held at 0, memReady ignored; memTimeout never sets.

## Timing
- Reset (synchronous): the cycle after reset is sampled high, state=IDLE, counter=0, memTimeout=0, all outputs 0.
- Reset takes priority over every transition, including mid-wait and HALT.
- Cycles per instruction with zero wait (FETCH through last state):
  - lw 5; sw, R-type, addi/andi/ori 4; beq/bne/j 3; illegal 2.
- Each memReady-low cycle in a memory state adds exactly one cycle.
- Timeout: memReady low for WAIT_LIMIT consecutive cycles in one memory state → HALT on the following edge.
  - memReady rising on the limit cycle is a normal completion; no timeout.
- Mealy outputs (FETCH irWrite/pcWrite, MEM_WRITE instrDone) follow memReady in the same cycle; all others depend on state only.

## Test plan
- Reset then R-type (OpCode=000000, memReady=1): state sequence 0,1,2,7,8,1; regDst=1/regWrite=1 in R_WB; instrDone high exactly 1 cycle.
- lw with memReady low 3 cycles in MEM_READ: 8 cycles FETCH→FETCH; iorD=1, memRead=1 throughout waits; memToReg=1, regWrite=1 in MEM_WB.
- bne (000101): BRANCH with pcWriteCond=1, branchNe=1, aluOp=001, pcSource=01; beq gives branchNe=0.
- ori (001101): IMM_EXEC aluOp=100, aluSrcB=10; IMM_WB regWrite=1, regDst=0; opcode 111111: illegalOp pulse, back in FETCH after 2 cycles.
- WAIT_LIMIT=4, memReady held 0 in FETCH: HALT after 4 wait cycles, memTimeout=1 sticky; reset clears to IDLE with all outputs 0.
- MEM_WAIT_EN=0, memReady=0 constantly: sw completes in 4 cycles; memTimeout stays 0.
